// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the RV64 memory-access stage.
// Size codes, FSM states, strobe bases and alignment helpers.
package mem_access_stage_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [7:0] STRB_B = 8'h01;
   localparam logic [7:0] STRB_H = 8'h03;
   localparam logic [7:0] STRB_W = 8'h0F;
   localparam logic [7:0] STRB_D = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // Unsigned variants share the size of their signed twin.
   function automatic logic [7:0] strb_base(input logic [1:0] sz);
      logic [7:0] s;
      case (sz)
         SZ_B:    s = STRB_B;
         SZ_H:    s = STRB_H;
         SZ_W:    s = STRB_W;
         default: s = STRB_D;
      endcase
      return s;
   endfunction

   function automatic logic is_aligned(input logic [1:0] sz,
                                       input logic [2:0] a);
      logic ok;
      case (sz)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = (a[0] == 1'b0);
         SZ_W:    ok = (a[1:0] == 2'b00);
         SZ_D:    ok = (a == 3'b000);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load extraction: pick the addressed lane out of a raw
// doubleword and sign/zero-extend it to 64 bits.
module mem_access_stage_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [63:0] i_rdata,
   input  logic [2:0]  i_lane,
   input  logic [2:0]  i_funct3,
   output logic [63:0] o_data
);

   logic [63:0] w_sh;

   assign w_sh = i_rdata >> {i_lane, 3'b000};

   // Size/sign selection on the lane-shifted data
   always_comb begin
      o_data = w_sh;
      case (i_funct3)
         F3_B:    o_data = {{56{w_sh[7]}}, w_sh[7:0]};
         F3_H:    o_data = {{48{w_sh[15]}}, w_sh[15:0]};
         F3_W:    o_data = {{32{w_sh[31]}}, w_sh[31:0]};
         F3_D:    o_data = i_rdata;
         F3_BU:   o_data = {56'b0, w_sh[7:0]};
         F3_HU:   o_data = {48'b0, w_sh[15:0]};
         F3_WU:   o_data = {32'b0, w_sh[31:0]};
         default: o_data = w_sh;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RV64 MEM stage: data-memory handshake, load extraction,
// store alignment, and stall/timeout control toward WB.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic [XLEN-1:0] aluResult_in,
   input  logic [XLEN-1:0] storeData_in,
   input  logic [4:0]      rd_in,
   input  logic [2:0]      funct3_in,
   input  logic            MemRead_in,
   input  logic            MemWrite_in,
   input  logic            MemtoReg_in,
   input  logic            RegWrite_in,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_wstrb,
   input  logic            dmem_ready,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] aluResult_out,
   output logic [XLEN-1:0] memData_out,
   output logic [4:0]      rd_out,
   output logic            MemtoReg_out,
   output logic            RegWrite_out,
   output logic            stall_out,
   output logic            misaligned_out,
   output logic            bus_err_out
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_alu;
   logic [XLEN-1:0] r_sdata;
   logic [XLEN-1:0] r_mdata;
   logic [4:0]      r_rd;
   logic [2:0]      r_f3;
   logic            r_we;
   logic            r_m2r;
   logic            r_rw;
   logic            r_done;
   logic            r_berr;

   logic            w_free;
   logic            w_memop;
   logic            w_align;
   logic            w_accept;
   logic            w_tmo;
   logic            w_req;
   logic [XLEN-1:0] w_ldata;

   // Completion and bus-error cycles still see the old
   // EX/MEM contents, so nothing is accepted in them.
   assign w_free   = (r_state == S_IDLE) & ~r_done & ~r_berr;
   assign w_memop  = MemRead_in | MemWrite_in;
   assign w_align  = is_aligned(funct3_in[1:0], aluResult_in[2:0]);
   assign w_accept = w_free & valid_in & w_memop & w_align;
   assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
   assign w_req    = (r_state == S_REQ);

   mem_access_stage_load_align u_load_align (
      .i_rdata  (dmem_rdata),
      .i_lane   (r_alu[2:0]),
      .i_funct3 (r_f3),
      .o_data   (w_ldata)
   );

   assign misaligned_out = w_free & valid_in & w_memop & ~w_align;
   assign bus_err_out    = r_berr;
   assign stall_out      = (r_state != S_IDLE) | w_accept;

   assign dmem_req   = w_req;
   assign dmem_we    = w_req & r_we;
   assign dmem_addr  = w_req ? {r_alu[XLEN-1:3], 3'b000} : '0;
   assign dmem_wdata = (w_req & r_we) ?
                       (r_sdata << {r_alu[2:0], 3'b000}) : '0;
   assign dmem_wstrb = (w_req & r_we) ?
                       (strb_base(r_f3[1:0]) << r_alu[2:0]) : 8'h00;

   // WB bundle: completed op, same-cycle passthrough, or bubble
   always_comb begin
      aluResult_out = '0;
      memData_out   = '0;
      rd_out        = 5'd0;
      MemtoReg_out  = 1'b0;
      RegWrite_out  = 1'b0;
      if (r_done) begin
         aluResult_out = r_alu;
         memData_out   = r_mdata;
         rd_out        = r_rd;
         MemtoReg_out  = r_m2r;
         RegWrite_out  = r_rw;
      end else if (w_free & valid_in & ~w_memop) begin
         aluResult_out = aluResult_in;
         rd_out        = rd_in;
         MemtoReg_out  = MemtoReg_in;
         RegWrite_out  = RegWrite_in;
      end
   end

   // Access FSM with capture registers and timeout counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_alu   <= '0;
         r_sdata <= '0;
         r_mdata <= '0;
         r_rd    <= 5'd0;
         r_f3    <= 3'd0;
         r_we    <= 1'b0;
         r_m2r   <= 1'b0;
         r_rw    <= 1'b0;
         r_done  <= 1'b0;
         r_berr  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_berr <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_REQ;
                  r_cnt   <= '0;
                  r_alu   <= aluResult_in;
                  r_sdata <= storeData_in;
                  r_mdata <= '0;
                  r_rd    <= rd_in;
                  r_f3    <= funct3_in;
                  r_we    <= MemWrite_in;
                  r_m2r   <= MemtoReg_in;
                  r_rw    <= RegWrite_in;
               end
            end
            S_REQ: begin
               if (dmem_ready) begin
                  if (r_we) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= r_cnt + CW'(1);
                  end
               end else if (w_tmo) begin
                  r_berr  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_WAIT: begin
               if (dmem_rvalid) begin
                  r_mdata <= w_ldata;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_tmo) begin
                  r_berr  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
